// File: rtl/filter_mode_ctrl.sv
// Frame-synchronous filter-mode controller: round-robin arbitration of two requesters,
// apply on frame_start, optional hold. Optional auto-cycle under FILTER_AUTO_CYCLE_EN.
module filter_mode_ctrl #(
    parameter int NUM_MODES   = 4,
    parameter int MODE_W      = 2,
    parameter int HOLD_FRAMES = 2,
    parameter int AUTO_FRAMES = 60
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              frame_start_i,
    input  logic [1:0]        req_valid_i,
    input  logic [MODE_W-1:0] req_mode0_i,
    input  logic [MODE_W-1:0] req_mode1_i,
    output logic [1:0]        req_ready_o,
    input  logic              auto_en_i,
    output logic [MODE_W-1:0] mode_sel_o,
    output logic              filter_en_o,
    output logic              mode_update_o,
    output logic              busy_o,
    output logic              req_err_o
);

    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    typedef enum logic [1:0] {IDLE, PENDING, HOLD} state_e;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic [MODE_W-1:0]   pend_mode_q, pend_mode_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [MODE_W-1:0]   mode_sel_q, mode_sel_d;
    logic                wr_q, wr_d;
    logic                err_d;
    logic                mode_update_q, req_err_q, busy_q, filter_en_q;
    logic [1:0]          gnt;
    logic [MODE_W-1:0]   gnt_mode;
    logic                xfer, gnt_legal;

`ifdef FILTER_AUTO_CYCLE_EN
    localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);
    logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
`else
    logic                unused_auto_en;
    assign unused_auto_en = auto_en_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Grant is derived from registered state only, so the transfer completes this cycle.
    always_comb begin
        gnt = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid_i)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        req_ready_o = gnt;
    end

    assign xfer      = |gnt;
    assign gnt_mode  = gnt[1] ? req_mode1_i : req_mode0_i;
    assign gnt_legal = int'(gnt_mode) < NUM_MODES;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        pend_mode_d = pend_mode_q;
        hold_cnt_d  = hold_cnt_q;
        mode_sel_d  = mode_sel_q;
        wr_d        = 1'b0;
        err_d       = 1'b0;
`ifdef FILTER_AUTO_CYCLE_EN
        auto_cnt_d  = auto_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i == 2'b11) rr_d = ~rr_q;
                if (xfer) begin
                    if (gnt_legal) begin
                        state_d     = PENDING;
                        pend_mode_d = gnt_mode;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`ifdef FILTER_AUTO_CYCLE_EN
                if (xfer || !auto_en_i) begin
                    auto_cnt_d = '0;
                end else if (req_valid_i == 2'b00 && frame_start_i) begin
                    if (int'(auto_cnt_q) + 1 >= AUTO_FRAMES) begin
                        auto_cnt_d = '0;
                        wr_d       = 1'b1;
                        mode_sel_d = (int'(mode_sel_q) == NUM_MODES - 1) ? '0
                                                                         : mode_sel_q + MODE_W'(1);
                    end else begin
                        auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                    end
                end
`endif
            end
            PENDING: begin
                if (frame_start_i) begin
                    mode_sel_d = pend_mode_q;
                    wr_d       = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = (HOLD_FRAMES == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (frame_start_i) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (int'(hold_cnt_q) + 1 >= HOLD_FRAMES) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // mode_update trails the mode_sel write by one cycle via wr_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q          <= 1'b0;
            pend_mode_q   <= '0;
            hold_cnt_q    <= '0;
            mode_sel_q    <= '0;
            wr_q          <= 1'b0;
            mode_update_q <= 1'b0;
            req_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            filter_en_q   <= 1'b0;
`ifdef FILTER_AUTO_CYCLE_EN
            auto_cnt_q    <= '0;
`endif
        end else begin
            rr_q          <= rr_d;
            pend_mode_q   <= pend_mode_d;
            hold_cnt_q    <= hold_cnt_d;
            mode_sel_q    <= mode_sel_d;
            wr_q          <= wr_d;
            mode_update_q <= wr_q;
            req_err_q     <= err_d;
            busy_q        <= (state_d != IDLE);
            filter_en_q   <= (mode_sel_d != '0);
`ifdef FILTER_AUTO_CYCLE_EN
            auto_cnt_q    <= auto_cnt_d;
`endif
        end
    end

    assign mode_sel_o    = mode_sel_q;
    assign filter_en_o   = filter_en_q;
    assign mode_update_o = mode_update_q;
    assign busy_o        = busy_q;
    assign req_err_o     = req_err_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Scoreboard bench for filter_mode_ctrl: stimulus pushes expected grants, mode updates
// and errors into queues; a negedge monitor pops and compares when the DUT presents them.
module tb_filter_mode_ctrl;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame;
    logic [1:0]    valid;
    logic [MW-1:0] m0, m1;
    logic [1:0]    ready;
    logic          auto_en;
    logic [MW-1:0] mode_sel;
    logic          filter_en, mode_update, busy, req_err;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]    gnt_q[$];
    logic [MW-1:0] mode_q[$];
    logic [MW-1:0] err_q[$];

    always #5 clk = ~clk;

    filter_mode_ctrl #(.NUM_MODES(4), .MODE_W(MW), .HOLD_FRAMES(2), .AUTO_FRAMES(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame), .req_valid_i(valid),
        .req_mode0_i(m0), .req_mode1_i(m1), .req_ready_o(ready), .auto_en_i(auto_en),
        .mode_sel_o(mode_sel), .filter_en_o(filter_en), .mode_update_o(mode_update),
        .busy_o(busy), .req_err_o(req_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ready != 2'b00) begin
                if (gnt_q.size() == 0) chk("grant_unexpected", 32'(ready), 0);
                else chk("grant", 32'(ready), 32'(gnt_q.pop_front()));
            end
            if (mode_update) begin
                if (mode_q.size() == 0) chk("update_unexpected", 32'(mode_sel), 32'hFFFF);
                else begin
                    logic [MW-1:0] e;
                    e = mode_q.pop_front();
                    chk("update_mode_sel", 32'(mode_sel), 32'(e));
                    chk("update_filter_en", 32'(filter_en), 32'(e != 0));
                end
            end
            if (req_err) begin
                if (err_q.size() == 0) chk("err_unexpected", 32'(req_err), 0);
                else chk("err_mode_sel_kept", 32'(mode_sel), 32'(err_q.pop_front()));
            end
        end
    end

    task automatic frame_pulse();
        @(posedge clk); #1 frame = 1'b1;
        @(posedge clk); #1 frame = 1'b0;
    endtask

    task automatic wait_rdy(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[p] && n < 50);
        chk("handshake", 32'(ready[p]), 1);
        @(posedge clk); #1 valid[p] = 1'b0;
    endtask

    task automatic req(input int p, input logic [MW-1:0] m);
        gnt_q.push_back(2'(1 << p));
        @(posedge clk); #1;
        if (p == 0) m0 = m; else m1 = m;
        valid[p] = 1'b1;
        wait_rdy(p);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mode_sel"}, 32'(mode_sel), 0);
        chk({tag, "_filter_en"}, 32'(filter_en), 0);
        chk({tag, "_mode_update"}, 32'(mode_update), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_req_err"}, 32'(req_err), 0);
        chk({tag, "_req_ready"}, 32'(ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; frame = 0; valid = 0; m0 = 0; m1 = 0; auto_en = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst_n = 1;

        // single request, applied on next frame, mode_update one cycle after mode_sel
        req(0, 1);
        @(negedge clk);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_not_yet", 32'(mode_sel), 0);
        mode_q.push_back(1);
        frame_pulse();
        @(negedge clk);
        chk("t1_applied", 32'(mode_sel), 1);
        chk("t1_update_delayed", 32'(mode_update), 0);
        frame_pulse(); frame_pulse();
        @(negedge clk);
        chk("t1_idle", 32'(busy), 0);

        // both requesters valid: rr gives port 0 first, port 1 after hold
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
        mode_q.push_back(2); mode_q.push_back(3);
        @(posedge clk); #1 m0 = 2; m1 = 3; valid = 2'b11;
        wait_rdy(0);
        frame_pulse();
        @(negedge clk);
        chk("t2_hold_no_grant", 32'(ready), 0);
        frame_pulse();
        @(negedge clk);
        chk("t2_hold_no_grant2", 32'(ready), 0);
        chk("t2_hold_busy", 32'(busy), 1);
        frame_pulse();
        wait_rdy(1);
        chk("t2_pending_mode", 32'(mode_sel), 2);
        frame_pulse();
        @(negedge clk);
        chk("t2_applied", 32'(mode_sel), 3);
        frame_pulse(); frame_pulse();

        // transfer coincident with frame_start is applied on the following frame
        gnt_q.push_back(2'b01);
        @(posedge clk); #1 m0 = 2; valid[0] = 1'b1; frame = 1'b1;
        @(posedge clk); #1 valid[0] = 1'b0; frame = 1'b0;
        @(negedge clk);
        chk("t3_unchanged", 32'(mode_sel), 3);
        chk("t3_busy", 32'(busy), 1);
        mode_q.push_back(2);
        frame_pulse();
        frame_pulse(); frame_pulse();

        // illegal mode: acked, error pulse, no state change
        err_q.push_back(2);
        req(1, 5);
        @(negedge clk);
        chk("t4_err_pulse", 32'(req_err), 1);
        chk("t4_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t4_err_single", 32'(req_err), 0);
        chk("t4_mode_kept", 32'(mode_sel), 2);

        // request equal to current mode still applies and pulses update
        mode_q.push_back(2);
        req(1, 2);
        frame_pulse();
        frame_pulse(); frame_pulse();

        // reset while PENDING discards the request
        req(0, 2);
        @(negedge clk);
        chk("t5_pending", 32'(busy), 1);
        #1 rst_n = 0;
        #1 chk_all_zero("t5_async");
        @(posedge clk); #1 rst_n = 1;
        frame_pulse();
        @(negedge clk);
        chk("t5_discarded", 32'(mode_sel), 0);
        chk("t5_idle", 32'(busy), 0);

`ifdef FILTER_AUTO_CYCLE_EN
        mode_q.push_back(3);
        req(0, 3);
        frame_pulse(); frame_pulse(); frame_pulse();
        @(posedge clk); #1 auto_en = 1'b1;
        frame_pulse(); frame_pulse();
        @(negedge clk);
        chk("t6_before_wrap", 32'(mode_sel), 3);
        mode_q.push_back(0);
        frame_pulse();
        @(negedge clk);
        chk("t6_wrap", 32'(mode_sel), 0);
        mode_q.push_back(1);
        frame_pulse(); frame_pulse(); frame_pulse();
        @(negedge clk);
        chk("t6_advance", 32'(mode_sel), 1);
        frame_pulse(); frame_pulse();
        err_q.push_back(1);
        req(0, 5);
        frame_pulse(); frame_pulse();
        @(negedge clk);
        chk("t6_cnt_cleared", 32'(mode_sel), 1);
        mode_q.push_back(2);
        frame_pulse();
        @(negedge clk);
        chk("t6_after_clear", 32'(mode_sel), 2);
        @(posedge clk); #1 auto_en = 1'b0;
`else
        @(posedge clk); #1 auto_en = 1'b1;
        frame_pulse(); frame_pulse(); frame_pulse(); frame_pulse();
        @(negedge clk);
        chk("t6_auto_ignored", 32'(mode_sel), 0);
        @(posedge clk); #1 auto_en = 1'b0;
`endif

        repeat (4) @(negedge clk);
        chk("gnt_q_drained", 32'(gnt_q.size()), 0);
        chk("mode_q_drained", 32'(mode_q.size()), 0);
        chk("err_q_drained", 32'(err_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
